// File: rtl/debug_cmd_pkg.sv
// Shared constants and types for the UART debug command decoder.
package debug_cmd_pkg;

  localparam logic [7:0] OP_STEP  = 8'h73;
  localparam logic [7:0] OP_RUN   = 8'h63;
  localparam logic [7:0] OP_STOP  = 8'h70;
  localparam logic [7:0] OP_RUNN  = 8'h6E;
  localparam logic [7:0] OP_DUMP  = 8'h64;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CNT_HI   = 3'd1,
    ST_CNT_LO   = 3'd2,
    ST_RUN_N    = 3'd3,
    ST_RUN_FREE = 3'd4
  } state_e;

endpackage

// File: rtl/debug_resp_reg.sv
// One-entry response holding register with a sticky overflow flag.
// Handshake: a byte is transferred on every clock edge where resp_valid_o && resp_ready_i;
// resp_valid_o never drops and resp_data_o never changes while a byte is pending and unaccepted.
module debug_resp_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid_i,
  input  logic [7:0] push_data_i,
  input  logic       resp_ready_i,
  output logic [7:0] resp_data_o,
  output logic       resp_valid_o,
  output logic       resp_overflow_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;
  logic       accept;

  assign accept = valid_q && resp_ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    // A new byte may replace one that leaves this very cycle; otherwise it is lost.
    if (push_valid_i) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = push_data_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign resp_data_o     = data_q;
  assign resp_valid_o    = valid_q;
  assign resp_overflow_o = ovf_q;

endmodule

// File: rtl/debug_cmd_decoder.sv
// Host command decoder for the UART debug link: gates the pipeline clock enable, launches
// dumps and answers every command with ACK/NAK. Optional inter-byte timeout: DBG_CMD_TIMEOUT_EN.
module debug_cmd_decoder
  import debug_cmd_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TIMEOUT_W   = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done_tick,
  input  logic             dump_busy,
  output logic             clk_en,
  output logic             dump_start,
  output logic [7:0]       resp_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_overflow,
  output logic [CNT_W-1:0] run_remaining,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic             clk_en_q, clk_en_d;
  logic             dump_start_q, dump_start_d;
  logic [CNT_W-1:0] run_rem_q, run_rem_d;
  logic [7:0]       cnt_hi_q, cnt_hi_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             push_valid;
  logic [7:0]       push_data;
  logic             byte_vld;
  logic [7:0]       byte_val;
  logic [15:0]      frame_cnt;
  logic             run_done;
  logic             in_frame;
  logic             tmo_hit;

  // A byte that lands on the run-N completion cycle is replayed one cycle later in IDLE.
  assign byte_vld  = pend_valid_q | rx_done_tick;
  assign byte_val  = pend_valid_q ? pend_q : rx_data;
  assign frame_cnt = {cnt_hi_q, byte_val};
  assign run_done  = (state_q == ST_RUN_N) && (run_rem_q == CNT_W'(1));
  assign in_frame  = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO);

`ifdef DBG_CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = in_frame && !byte_vld && (tmo_q == TIMEOUT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (in_frame && !byte_vld && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^{in_frame, TIMEOUT_W'(TIMEOUT_CYC)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_vld) begin
          if (byte_val == OP_RUN) begin
            state_d = ST_RUN_FREE;
          end else if (byte_val == OP_RUNN) begin
            state_d = ST_CNT_HI;
          end
        end
      end
      ST_CNT_HI: begin
        if (tmo_hit) begin
          state_d = ST_IDLE;
        end else if (byte_vld) begin
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (tmo_hit) begin
          state_d = ST_IDLE;
        end else if (byte_vld) begin
          state_d = (frame_cnt == 16'd0) ? ST_IDLE : ST_RUN_N;
        end
      end
      ST_RUN_N: begin
        if (run_done || (byte_vld && byte_val == OP_STOP)) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN_FREE: begin
        if (byte_vld && byte_val == OP_STOP) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_en_d     = 1'b0;
    dump_start_d = 1'b0;
    run_rem_d    = run_rem_q;
    cnt_hi_d     = cnt_hi_q;
    pend_d       = pend_q;
    pend_valid_d = 1'b0;
    push_valid   = 1'b0;
    push_data    = RESP_NAK;
    case (state_q)
      ST_IDLE: begin
        if (byte_vld) begin
          push_valid = 1'b1;
          case (byte_val)
            OP_STEP: begin
              clk_en_d  = 1'b1;
              push_data = RESP_ACK;
            end
            OP_RUN: begin
              clk_en_d  = 1'b1;
              push_data = RESP_ACK;
            end
            OP_STOP: push_data = RESP_ACK;
            OP_RUNN: push_valid = 1'b0;
            OP_DUMP: begin
              if (!dump_busy) begin
                dump_start_d = 1'b1;
                push_data    = RESP_ACK;
              end
            end
            default: push_data = RESP_NAK;
          endcase
        end
      end
      ST_CNT_HI: begin
        if (tmo_hit) begin
          push_valid = 1'b1;
        end else if (byte_vld) begin
          cnt_hi_d = byte_val;
        end
      end
      ST_CNT_LO: begin
        if (tmo_hit) begin
          push_valid = 1'b1;
        end else if (byte_vld) begin
          if (frame_cnt == 16'd0) begin
            push_valid = 1'b1;
          end else begin
            clk_en_d  = 1'b1;
            run_rem_d = CNT_W'(frame_cnt);
          end
        end
      end
      ST_RUN_N: begin
        if (run_done) begin
          run_rem_d  = '0;
          push_valid = 1'b1;
          push_data  = RESP_ACK;
          if (byte_vld) begin
            pend_d       = byte_val;
            pend_valid_d = 1'b1;
          end
        end else if (byte_vld && byte_val == OP_STOP) begin
          run_rem_d  = '0;
          push_valid = 1'b1;
          push_data  = RESP_ACK;
        end else begin
          clk_en_d   = 1'b1;
          run_rem_d  = run_rem_q - 1'b1;
          push_valid = byte_vld;
        end
      end
      ST_RUN_FREE: begin
        if (byte_vld && byte_val == OP_STOP) begin
          push_valid = 1'b1;
          push_data  = RESP_ACK;
        end else begin
          clk_en_d   = 1'b1;
          push_valid = byte_vld;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_en_q     <= 1'b0;
      dump_start_q <= 1'b0;
      run_rem_q    <= '0;
      cnt_hi_q     <= 8'h00;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
    end else begin
      clk_en_q     <= clk_en_d;
      dump_start_q <= dump_start_d;
      run_rem_q    <= run_rem_d;
      cnt_hi_q     <= cnt_hi_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  debug_resp_reg u_resp (
    .clk            (clk),
    .reset          (reset),
    .push_valid_i   (push_valid),
    .push_data_i    (push_data),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_valid_o   (resp_valid),
    .resp_overflow_o(resp_overflow)
  );

  assign clk_en        = clk_en_q;
  assign dump_start    = dump_start_q;
  assign run_remaining = run_rem_q;
  assign dbg_state     = state_q;

endmodule
